// File: rtl/msrv32_redirect_ctrl.sv
// Execute-stage PC redirect controller: redirect handshake to fetch, flush window,
// misaligned-target trap pulse and taken-redirect counter.
module msrv32_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             ex_valid_in,
  input  logic             branch_taken_in,
  input  logic [31:0]      target_in,
  input  logic             stall_in,
  input  logic             imem_ready_in,
  output logic             redirect_valid_out,
  output logic [31:0]      redirect_pc_out,
  output logic             flush_out,
  output logic             misaligned_trap_out,
  output logic [31:0]      misaligned_addr_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] taken_count_out
);

  typedef enum logic [1:0] {StIdle, StRedir, StFlush} state_e;

  state_e           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             flush_q, flush_d;
  logic             trap_q, trap_d;
  logic [31:0]      trap_addr_q, trap_addr_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic capture;
  logic handshake;

  assign capture   = ex_valid_in & branch_taken_in & ~stall_in & (state_q == StIdle);
  assign handshake = redirect_valid_q & imem_ready_in;

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    trap_d           = 1'b0;
    trap_addr_d      = trap_addr_q;
    busy_d           = busy_q;
    count_d          = count_q;

    unique case (state_q)
      StIdle: begin
        // Drops the single-cycle flush that accompanies a trap.
        flush_d = 1'b0;
        if (capture) begin
          flush_d = 1'b1;
          if (target_in[1:0] == 2'b00) begin
            state_d          = StRedir;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target_in;
            busy_d           = 1'b1;
          end else begin
            trap_d      = 1'b1;
            trap_addr_d = target_in;
          end
        end
      end
      StRedir: begin
        if (handshake) begin
          redirect_valid_d = 1'b0;
          count_d          = count_q + CNT_W'(1);
          if (FLUSH_CYCLES == 1) begin
            state_d = StIdle;
            flush_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            state_d     = StFlush;
            flush_cnt_d = 4'(FLUSH_CYCLES - 1);
          end
        end
      end
      StFlush: begin
        flush_cnt_d = flush_cnt_q - 4'd1;
        if (flush_cnt_q <= 4'd1) begin
          state_d = StIdle;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q          <= StIdle;
      flush_cnt_q      <= 4'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      trap_q           <= 1'b0;
      trap_addr_q      <= 32'd0;
      busy_q           <= 1'b0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      trap_q           <= trap_d;
      trap_addr_q      <= trap_addr_d;
      busy_q           <= busy_d;
      count_q          <= count_d;
    end
  end

  assign redirect_valid_out  = redirect_valid_q;
  assign redirect_pc_out     = redirect_pc_q;
  assign flush_out           = flush_q;
  assign misaligned_trap_out = trap_q;
  assign misaligned_addr_out = trap_addr_q;
  assign busy_out            = busy_q;
  assign taken_count_out     = count_q;

endmodule
